// File: rtl/dumper_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dumper_pkg
// Description : Shared types and helpers for the BSRAM-to-UART read-back
//               dumper: FSM state encoding, bit-period calculation and the
//               default frame sync byte.
// Revision    : 1.0 - initial release
// ============================================================================
package dumper_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SYNC     = 4'd1,
        ST_RD_ISSUE = 4'd2,
        ST_RD_WAIT  = 4'd3,
        ST_TX_HI    = 4'd4,
        ST_TX_LO    = 4'd5,
        ST_SUM      = 4'd6,
        ST_FIN      = 4'd7
    } dumper_state_t;

    localparam logic [7:0] c_sync_byte_default = 8'hA5;

    // Clocks per UART bit, integer-truncated.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage : dumper_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 UART transmitter with a valid/ready byte interface.
//               A byte is taken when tx_valid and tx_ready are both high.
//               tx_ready is also raised in the last clock of a stop bit so a
//               queued byte follows with no idle gap on the line.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               tx_valid      - byte offered
//               tx_data[7:0]  - byte to send (held while tx_valid)
//               tx_ready      - transmitter can accept a byte this cycle
//               uart_tx       - serial line, idle high
//               tx_idle       - no frame in flight (stop bit finished)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_idle
);

    localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic               r_active;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_shift;

    logic w_bit_end;
    logic w_last;
    logic w_load;

    assign w_bit_end = (r_baud_cnt == c_baud_last);
    // Final clock of the stop bit: a new byte may be loaded on this edge.
    assign w_last    = r_active & w_bit_end & (r_bit_cnt == 4'd9);
    assign tx_ready  = ~r_active | w_last;
    assign w_load    = tx_valid & tx_ready;
    assign tx_idle   = ~r_active;
    // Gate the line with r_active so an asynchronous reset forces it high
    // at once, without finishing any bit in progress.
    assign uart_tx   = r_active ? r_shift[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 10'h3FF;
        end else if (w_load) begin
            r_active   <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= {1'b1, tx_data, 1'b0};
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
        end
    end

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/bsram_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : bsram_uart_dumper
// Description : Reads a contiguous range of 16-bit BSRAM words and streams
//               them over UART as: sync byte, each word high byte first,
//               then an 8-bit checksum of the data bytes.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start               - request, accepted only while idle
//               start_addr          - first word address
//               word_count          - words to dump, 0..2**ADDR_W
//               mem_req             - this block owns the BSRAM port
//               mem_ad, mem_ce      - BSRAM read address / chip enable
//               mem_dout            - BSRAM read data
//               uart_tx             - serial output, 8N1, idle high
//               busy                - frame in progress
//               done                - one-cycle pulse at end of frame
// Revision    : 1.0 - initial release
// ============================================================================
module bsram_uart_dumper
    import dumper_pkg::*;
#(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         BAUD         = 57600,
    parameter int         ADDR_W       = 11,
    parameter int         DATA_W       = 16,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] SYNC_BYTE    = c_sync_byte_default
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_ad,
    output logic              mem_ce,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);

    dumper_state_t     r_state;
    dumper_state_t     w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_word_q;
    logic [7:0]        r_checksum;
    logic [3:0]        r_lat_cnt;
    logic              r_sum_sent;

    logic              w_tx_valid;
    logic [7:0]        w_tx_data;
    logic              w_tx_ready;
    logic              w_tx_idle;
    logic              w_hs;

    assign w_hs = w_tx_valid & w_tx_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (w_tx_valid),
        .tx_data  (w_tx_data),
        .tx_ready (w_tx_ready),
        .uart_tx  (uart_tx),
        .tx_idle  (w_tx_idle)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and byte offer to the transmitter. Each byte is offered
    // while the previous one is still shifting out; the transmitter takes
    // it in the last stop-bit clock, so the line carries no gaps.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_SYNC;
            end
            ST_SYNC: begin
                w_tx_valid = 1'b1;
                w_tx_data  = SYNC_BYTE;
                if (w_tx_ready) begin
                    w_next = (r_count == '0) ? ST_SUM : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                w_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == 4'd0) w_next = ST_TX_HI;
            end
            ST_TX_HI: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_word_q[15:8];
                if (w_tx_ready) w_next = ST_TX_LO;
            end
            ST_TX_LO: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_word_q[7:0];
                if (w_tx_ready) begin
                    // The next read overlaps the low byte's serialisation.
                    w_next = (r_count == (ADDR_W+1)'(1)) ? ST_SUM : ST_RD_ISSUE;
                end
            end
            ST_SUM: begin
                if (!r_sum_sent) begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = r_checksum;
                end else if (w_tx_idle) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address/count, read latency, word capture, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_word_q   <= '0;
            r_checksum <= 8'h00;
            r_lat_cnt  <= 4'd0;
            r_sum_sent <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr     <= start_addr;
                        r_count    <= word_count;
                        r_checksum <= 8'h00;
                        r_sum_sent <= 1'b0;
                    end
                end
                ST_RD_ISSUE: begin
                    r_lat_cnt <= 4'(READ_LATENCY - 1);
                end
                ST_RD_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_word_q <= mem_dout;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                ST_TX_HI: begin
                    if (w_hs) r_checksum <= r_checksum + r_word_q[15:8];
                end
                ST_TX_LO: begin
                    if (w_hs) begin
                        r_checksum <= r_checksum + r_word_q[7:0];
                        r_addr     <= r_addr + 1'b1;   // wraps modulo 2**ADDR_W
                        r_count    <= r_count - 1'b1;
                    end
                end
                ST_SUM: begin
                    if (w_hs) r_sum_sent <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign mem_req = (r_state != ST_IDLE);
    assign mem_ce  = (r_state == ST_RD_ISSUE);
    assign mem_ad  = r_addr;
    assign done    = (r_state == ST_FIN);

endmodule : bsram_uart_dumper
`default_nettype wire
